// File: rtl/lut_layer_pipe.sv
// Layer of LUT neurons: each neuron looks up its own flop-based truth table,
// behind a two-stage valid/ready pipeline with a side-band table write port.
module lut_layer_pipe #(
  parameter int NEURONS  = 8,
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1,
  // One extra index code so an out-of-range neuron can actually be addressed.
  localparam int NB = ($clog2(NEURONS + 1) < 1) ? 1 : $clog2(NEURONS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NEURONS*IN_BITS-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NEURONS*OUT_BITS-1:0]  out_data,
  input  logic                         cfg_we,
  input  logic [NB-1:0]                cfg_neuron,
  input  logic [IN_BITS-1:0]           cfg_addr,
  input  logic [OUT_BITS-1:0]          cfg_data,
  output logic                         cfg_err
);

  localparam int DEPTH = 2 ** IN_BITS;

  logic [OUT_BITS-1:0]         tbl [NEURONS][DEPTH];
  logic [NEURONS*IN_BITS-1:0]  s1_data;
  logic                        s1_valid;
  logic [NEURONS*OUT_BITS-1:0] s2_data;
  logic                        s2_valid;
  logic [NEURONS*OUT_BITS-1:0] lookup;
  logic                        adv2;
  logic                        cfg_hit;

  assign adv2      = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || adv2;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;

  // NOTE: every variable driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    lookup = '0;
    for (int n = 0; n < NEURONS; n++) begin
      lookup[n*OUT_BITS +: OUT_BITS] = tbl[n][s1_data[n*IN_BITS +: IN_BITS]];
    end
  end

  always_comb begin
    cfg_hit = 1'b0;
    for (int n = 0; n < NEURONS; n++) begin
      if (cfg_neuron == NB'(n)) cfg_hit = 1'b1;
    end
  end

  // NOTE: tables are real flops that must read as zero after reset, so this
  // memory is cleared in the reset branch rather than left uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NEURONS; n++) begin
        for (int a = 0; a < DEPTH; a++) begin
          tbl[n][a] <= '0;
        end
      end
    end else if (cfg_we) begin
      for (int n = 0; n < NEURONS; n++) begin
        if (cfg_neuron == NB'(n)) tbl[n][cfg_addr] <= cfg_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else if (cfg_we && !cfg_hit) begin
      cfg_err <= 1'b1;
    end
  end

  // NOTE: non-blocking assignments let S2 sample the lookup of the old S1
  // contents and the old table on the same edge S1 and the table update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s2_data  <= '0;
      s2_valid <= 1'b0;
    end else begin
      if (adv2) begin
        s2_data  <= lookup;
        s2_valid <= s1_valid;
      end
      if (in_ready) begin
        s1_data  <= in_data;
        s1_valid <= in_valid;
      end
    end
  end

endmodule

// File: tb/tb_lut_layer_pipe.sv
// Self-checking bench for lut_layer_pipe: queue-based reference model with a
// per-cycle compare, directed scenarios with literal expectations, random traffic.
module tb_lut_layer_pipe;

  localparam int N   = 8;
  localparam int IB  = 6;
  localparam int OB  = 1;
  localparam int NB  = 4;
  localparam int DW  = N * IB;
  localparam int OW  = N * OB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          cfg_we;
  logic [NB-1:0] cfg_neuron;
  logic [IB-1:0] cfg_addr;
  logic [OB-1:0] cfg_data;
  logic          cfg_err;

  int checks   = 0;
  int failures = 0;

  lut_layer_pipe #(.NEURONS(N), .IN_BITS(IB), .OUT_BITS(OB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted vectors wait in q_addr until the output slot is
  // free (or being emptied); they are then looked up against the table as it
  // stands before that edge's write, and wait in q_res until delivered.
  logic [OB-1:0] m_tbl [N][2**IB];
  logic [DW-1:0] q_addr [$];
  logic [OW-1:0] q_res  [$];
  logic          m_err;
  bit            m_free, m_rdy;

  function automatic logic [OW-1:0] model_lookup(input logic [DW-1:0] v);
    logic [OW-1:0] r;
    r = '0;
    for (int n = 0; n < N; n++) r[n*OB +: OB] = m_tbl[n][v[n*IB +: IB]];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_addr.delete();
      q_res.delete();
      m_err <= 1'b0;
      for (int n = 0; n < N; n++)
        for (int a = 0; a < 2**IB; a++) m_tbl[n][a] <= '0;
    end else begin
      m_free = (q_res.size() == 0) || out_ready;
      m_rdy  = (q_addr.size() == 0) || m_free;
      if (q_res.size() != 0 && out_ready) void'(q_res.pop_front());
      if (m_free && q_addr.size() != 0) q_res.push_back(model_lookup(q_addr.pop_front()));
      if (cfg_we) begin
        if (int'(cfg_neuron) < N) m_tbl[int'(cfg_neuron)][cfg_addr] <= cfg_data;
        else m_err <= 1'b1;
      end
      if (in_valid && m_rdy) q_addr.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    check("model_in_ready", {63'b0, in_ready},
          {63'b0, (q_addr.size() == 0) || (q_res.size() == 0) || out_ready});
    check("model_out_valid", {63'b0, out_valid}, {63'b0, q_res.size() != 0});
    if (q_res.size() != 0) check("model_out_data", 64'(out_data), 64'(q_res[0]));
    check("model_cfg_err", {63'b0, cfg_err}, {63'b0, m_err});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic cfg_write(input int n, input int a, input int d);
    cfg_we     = 1'b1;
    cfg_neuron = NB'(n);
    cfg_addr   = IB'(a);
    cfg_data   = OB'(d);
    step();
    cfg_we     = 1'b0;
  endtask

  logic [DW-1:0] vecs [4];
  logic [OB-1:0] rec  [4];
  int idx, ndel, acc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
    #22;
    check("reset_in_ready", {63'b0, in_ready}, 64'd1);
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_cfg_err", {63'b0, cfg_err}, 64'd0);
    step();
    rst_n = 1'b1;
    check("post_reset_in_ready", {63'b0, in_ready}, 64'd1);

    // Defaults, all-ones address: result after exactly two edges is zero.
    in_valid = 1'b1; in_data = '1;
    step();
    in_valid = 1'b0;
    check("lat_after_1edge", {63'b0, out_valid}, 64'd0);
    step();
    check("lat_after_2edges", {63'b0, out_valid}, 64'd1);
    check("defaults_out_data", 64'(out_data), 64'h00);
    step();

    // Program neuron 0 and stream four addresses back-to-back.
    cfg_write(0, 'h3A, 1); cfg_write(0, 'h1B, 1); cfg_write(0, 'h3B, 1);
    cfg_write(0, 'h1F, 1); cfg_write(0, 'h3F, 1);
    vecs[0] = DW'('h3A); vecs[1] = DW'('h1B); vecs[2] = DW'('h00); vecs[3] = DW'('h3F);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 4);
      in_data  = (i < 4) ? vecs[i] : '0;
      step();
      if (i >= 1) begin
        check($sformatf("stream_valid_%0d", i - 1), {63'b0, out_valid}, 64'd1);
        rec[i-1] = out_data[0 +: OB];
      end
    end
    in_valid = 1'b0;
    check("stream_res_0", 64'(rec[0]), 64'd1);
    check("stream_res_1", 64'(rec[1]), 64'd1);
    check("stream_res_2", 64'(rec[2]), 64'd0);
    check("stream_res_3", 64'(rec[3]), 64'd1);
    step();

    // Backpressure: five stalled cycles during a four-vector stream.
    vecs[0] = DW'('h3A); vecs[1] = DW'('h00); vecs[2] = DW'('h1B); vecs[3] = DW'('h01);
    out_ready = 1'b0; idx = 0; acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 4);
      in_data  = vecs[idx % 4];
      settle();
      if (c >= 2) begin
        check("stall_out_valid", {63'b0, out_valid}, 64'd1);
        check("stall_out_hold", 64'(out_data[0 +: OB]), 64'd1);
      end
      if (in_ready && in_valid) begin idx++; acc++; end
      step();
    end
    check("stall_accepts", 64'(acc), 64'd2);
    check("stall_in_ready_low", {63'b0, in_ready}, 64'd0);
    out_ready = 1'b1; ndel = 0;
    for (int c = 0; c < 20 && ndel < 4; c++) begin
      in_valid = (idx < 4);
      in_data  = vecs[idx % 4];
      settle();
      if (out_valid) begin rec[ndel] = out_data[0 +: OB]; ndel++; end
      if (in_ready && in_valid) idx++;
      step();
    end
    in_valid = 1'b0;
    check("stall_delivered", 64'(ndel), 64'd4);
    check("stall_order_0", 64'(rec[0]), 64'd1);
    check("stall_order_1", 64'(rec[1]), 64'd0);
    check("stall_order_2", 64'(rec[2]), 64'd1);
    check("stall_order_3", 64'(rec[3]), 64'd0);
    step(); step();

    // Write table[2][5] on the edge S2 captures a neuron-2 addr-5 vector.
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = DW'(5) << (2 * IB);
    step();
    cfg_we = 1'b1; cfg_neuron = NB'(2); cfg_addr = IB'(5); cfg_data = OB'(1);
    step();
    cfg_we = 1'b0; in_valid = 1'b0;
    check("same_edge_valid", {63'b0, out_valid}, 64'd1);
    check("same_edge_old", 64'(out_data[2*OB +: OB]), 64'd0);
    step();
    check("next_vec_valid", {63'b0, out_valid}, 64'd1);
    check("next_vec_new", 64'(out_data[2*OB +: OB]), 64'd1);
    step();

    // Out-of-range neuron index sets the sticky error and writes nothing.
    do_reset();
    cfg_write(8, 5, 1);
    check("cfg_err_set", {63'b0, cfg_err}, 64'd1);
    in_valid = 1'b1; in_data = {N{IB'(5)}};
    step();
    in_valid = 1'b0;
    step();
    check("oor_tables_valid", {63'b0, out_valid}, 64'd1);
    check("oor_tables_zero", 64'(out_data), 64'd0);
    step();
    check("cfg_err_sticky", {63'b0, cfg_err}, 64'd1);
    do_reset();
    check("cfg_err_cleared", {63'b0, cfg_err}, 64'd0);

    // Asynchronous reset with both stages full.
    cfg_write(1, 7, 1);
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(7) << IB;
    step(); step();
    in_valid = 1'b0;
    check("full_before_reset", {63'b0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", {63'b0, out_valid}, 64'd0);
    check("async_out_data", 64'(out_data), 64'd0);
    check("async_in_ready", {63'b0, in_ready}, 64'd1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("no_ghost_output", {63'b0, out_valid}, 64'd0);
    end

    // Random traffic, stalls and table writes (including out-of-range ones).
    for (int c = 0; c < 2000; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = DW'({$urandom(), $urandom()});
      out_ready  = ($urandom_range(0, 3) != 0);
      cfg_we     = ($urandom_range(0, 3) == 0);
      cfg_neuron = NB'($urandom_range(0, (c < 1500) ? N - 1 : N + 1));
      cfg_addr   = IB'($urandom());
      cfg_data   = OB'($urandom());
      step();
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
